// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request in, LATENCY wait states, one-cycle response.
// Optional misaligned/illegal byte-enable trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  Lat   = 4'(LATENCY);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                  state_q;
    logic [3:0]              cnt_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic [3:0]              be_q;
    logic                    err_q;
    logic                    req_ready_q;
    logic                    rsp_valid_q;
    logic                    rsp_err_q;
    logic [31:0]             rsp_rdata_q;
    logic [31:0]             mem_q [Depth];

    logic [ADDR_WIDTH-1:0]   req_idx;
    logic                    req_err;
    logic                    unused_addr;

    assign req_idx     = req_addr_i[ADDR_WIDTH+1:2];
    assign unused_addr = ^{req_addr_i[31:ADDR_WIDTH+2], req_addr_i[1:0]};

`ifdef DMEM_MISALIGN_TRAP_EN
    always_comb begin
        req_err = 1'b0;
        case (req_be_i)
            4'b1111:                            req_err = (req_addr_i[1:0] != 2'b00);
            4'b0011, 4'b1100:                   req_err = req_addr_i[0];
            4'b0001, 4'b0010, 4'b0100, 4'b1000: req_err = 1'b0;
            default:                            req_err = 1'b1;
        endcase
    end
`else
    assign req_err = 1'b0;
`endif

    // With zero latency the commit edge is the accept edge, so use the live request fields.
    logic                  in_idle;
    logic                  commit;
    logic                  c_we;
    logic                  c_err;
    logic [ADDR_WIDTH-1:0] c_idx;
    logic [31:0]           c_wdata;
    logic [3:0]            c_be;

    assign in_idle = (state_q == StIdle);
    assign commit  = (in_idle && req_valid_i && (LATENCY == 0)) ||
                     ((state_q == StWait) && (cnt_q == 4'd1));
    assign c_we    = in_idle ? req_we_i    : we_q;
    assign c_err   = in_idle ? req_err     : err_q;
    assign c_idx   = in_idle ? req_idx     : idx_q;
    assign c_wdata = in_idle ? req_wdata_i : wdata_q;
    assign c_be    = in_idle ? req_be_i    : be_q;

    // The memory array shares the flop block but is never cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= 32'd0;
            be_q        <= 4'd0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            if (commit) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= c_err;
                if (c_we) begin
                    if (!c_err) begin
                        for (int i = 0; i < 4; i++) begin
                            if (c_be[i]) mem_q[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
                        end
                    end
                end else if (!c_err) begin
                    rsp_rdata_q <= mem_q[c_idx];
                end
            end
            case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        we_q        <= req_we_i;
                        idx_q       <= req_idx;
                        wdata_q     <= req_wdata_i;
                        be_q        <= req_be_i;
                        err_q       <= req_err;
                        cnt_q       <= Lat;
                        req_ready_q <= 1'b0;
                        state_q     <= (LATENCY == 0) ? StResp : StWait;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= StResp;
                end
                StResp: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table of back-to-back requests, scoreboard of expected responses,
// plus a hand-written reset-during-wait sequence.
module tb_dmem_responder;

    localparam int unsigned AW  = 6;
    localparam int unsigned LAT = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit Trap = 1'b1;
`else
    localparam bit Trap = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_responder #(
        .ADDR_WIDTH (AW),
        .LATENCY    (LAT)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_be_i    (req_be),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rd;   // read result without trap
        logic [31:0] rdt;  // read result with trap
        bit          et;   // error expected with trap
    } vec_t;
    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Drives one request, holds it until accepted, returns the accept edge number.
    task automatic send(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input bit push, input logic [31:0] erd,
                        input bit eerr, output int acc);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", {31'd0, req_ready}, 32'd1);
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = edge_cnt;
        if (push) sbq.push_back('{rdata: erd, err: eerr, due: acc + int'(LAT)});
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #2;
        check("drain_pending", 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    // Response monitor: every rsp_valid pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("rsp_edge", 32'(edge_cnt), 32'(e.due));
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        int          prev;
        logic [31:0] last_rd;
        bit          exp_err;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1111, 32'h0, 32'h0, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0020, 32'h0000_00AA, 4'b0001, 32'h0, 32'h0, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0020, 32'h0000_BB00, 4'b0010, 32'h0, 32'h0, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0020, 32'h0,         4'b1111, 32'h1122_BBAA, 32'h1122_BBAA, 1'b0};
        vecs[6]  = '{1'b1, 32'h0000_0100, 32'h0000_CAFE, 4'b1111, 32'h0, 32'h0, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         4'b1111, 32'h0000_CAFE, 32'h0000_CAFE, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0044, 32'hA5A5_A5A5, 4'b1111, 32'h0, 32'h0, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0044, 32'hFFFF_FFFF, 4'b0000, 32'h0, 32'h0, 1'b1};
        vecs[10] = '{1'b0, 32'h0000_0044, 32'h0,         4'b1111, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0};
        vecs[11] = '{1'b1, 32'h0000_0044, 32'h0077_0000, 4'b0100, 32'h0, 32'h0, 1'b0};
        vecs[12] = '{1'b1, 32'h0000_0044, 32'h8800_0000, 4'b1000, 32'h0, 32'h0, 1'b0};
        vecs[13] = '{1'b1, 32'h0000_0044, 32'h0000_DEAD, 4'b0011, 32'h0, 32'h0, 1'b0};
        vecs[14] = '{1'b0, 32'hFFFF_FF44, 32'h0,         4'b1111, 32'h8877_DEAD, 32'h8877_DEAD, 1'b0};
        vecs[15] = '{1'b1, 32'h0000_0022, 32'h5555_AAAA, 4'b1111, 32'h0, 32'h0, 1'b1};
        vecs[16] = '{1'b0, 32'h0000_0020, 32'h0,         4'b1111, 32'h5555_AAAA, 32'h1122_BBAA, 1'b0};
        vecs[17] = '{1'b1, 32'h0000_0044, 32'h1234_5678, 4'b0101, 32'h0, 32'h0, 1'b1};
        vecs[18] = '{1'b0, 32'h0000_0044, 32'h0,         4'b1111, 32'h8834_DE78, 32'h8877_DEAD, 1'b0};

        #2 rst_n = 1'b0;
        #1;
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Table: req_valid stays high throughout, so accepts must be LAT+2 edges apart.
        last_rd = 32'd0;
        prev    = 0;
        for (int i = 0; i < 19; i++) begin
            exp_err = Trap ? vecs[i].et : 1'b0;
            if (!vecs[i].we && !exp_err) last_rd = Trap ? vecs[i].rdt : vecs[i].rd;
            send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 1'b1, last_rd, exp_err, acc);
            if (i > 0) check("accept_spacing", 32'(acc - prev), 32'(LAT + 2));
            prev = acc;
        end
        idle();
        drain();

        // Reset during WAIT: the pending write must never land and no response may appear.
        send(1'b1, 32'h0000_0030, 32'h0, 4'b1111, 1'b1, last_rd, 1'b0, acc);
        idle();
        drain();
        send(1'b1, 32'h0000_0030, 32'h1234_5678, 4'b1111, 1'b0, 32'h0, 1'b0, acc);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("midreset_req_ready", {31'd0, req_ready}, 32'd1);
        check("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midreset_rsp_rdata", rsp_rdata, 32'd0);
        check("midreset_rsp_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        send(1'b0, 32'h0000_0030, 32'h0, 4'b1111, 1'b1, 32'h0000_0000, 1'b0, acc);
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the memory end of the MIPS core's load/store request interface.
- Accepts one request at a time through a valid/ready handshake and inserts LATENCY wait states.
- Performs byte-enabled writes (sw/sh/sb) or full-word reads, then returns a single-cycle response.
- Sits between the datapath load/store unit and the testbench-visible data memory array.

Parameters:
- ADDR_WIDTH, 6, word-index width; DEPTH = 2**ADDR_WIDTH words of 32 bits.
- LATENCY, 2, wait-state cycles between accept and response; legal range 0..15.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address; word index = req_addr[ADDR_WIDTH+1:2], upper bits ignored (wrap modulo DEPTH).
- req_wdata  input  32  write data, byte lanes aligned to word.
- req_be  input  4  byte enables; bit i selects bits [8i+7:8i].
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  32  registered read data; holds until next read response.
- rsp_err  output  1  error flag, qualified by rsp_valid.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Memory array is not cleared. Any pending request is discarded, and a write not yet committed is never performed.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready at an edge: capture we/addr/wdata/be and load counter=LATENCY.
  - Next state is WAIT if LATENCY>0, else RESP.
- WAIT:
  - req_ready=0; counter decrements each edge.
  - When counter==1 at an edge, next state is RESP.
  - req_* inputs are ignored while in WAIT.
- Commit point, the edge entering RESP:
  - Write: update only the lanes where be=1; other lanes are unchanged.
  - Read: rsp_rdata <= full word at index (be ignored for reads).
  - Write does not change rsp_rdata.
- RESP:
  - rsp_valid=1 for exactly one cycle, with no backpressure; req_ready=0.
  - Next state is IDLE.
- Timing:
  - Accept edge at cycle N gives rsp_valid high during cycle N+LATENCY+1.
  - Peak throughput is one request per LATENCY+2 cycles.
- A request arriving while not in IDLE is not accepted. The initiator must hold req_valid and its fields until req_ready handshake.
- Read-after-write to the same address in consecutive transactions returns the newly written bytes.
- req_be==4'b0000 write: no lanes change; the response is still issued.
- LATENCY==0: IDLE -> RESP -> IDLE, a 2-cycle turnaround.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- When defined, at accept the responder flags an error if any of the following holds:
  - be==4'b1111 and addr[1:0]!=0;
  - be in {0011,1100} and addr[0]==1;
  - be==0000;
  - be not in {0001,0010,0100,1000,0011,1100,1111}.
- On error: no memory write; rsp_rdata unchanged; rsp_err=1 together with rsp_valid; timing is identical to a normal response.
- When undefined: addr[1:0] is ignored, all be patterns are legal, and rsp_err is tied 0.

Test Plan:
- Reset then LATENCY=2: write addr 0x10, data 0xDEADBEEF, be=1111 accepted at cycle 5 -> rsp_valid only in cycle 8, rsp_err=0; read 0x10 -> rsp_rdata=0xDEADBEEF.
- Byte write: prior word 0x11223344 at 0x20; write 0x000000AA be=0001 then 0x0000BB00 be=0010 -> read returns 0x1122BBAA.
- Wrap: ADDR_WIDTH=6; write 0x0000CAFE to addr 0x100 -> read addr 0x000 returns 0x0000CAFE.
- Back-to-back: req_valid held high for 3 reads -> req_ready low in WAIT/RESP; accepts exactly every 4 cycles (LATENCY=2); no request dropped or duplicated.
- Reset mid-op: write 0x12345678 to 0x30 over prior 0x0, reset pulled low during WAIT for 1 cycle -> rsp_valid never asserts, outputs return to reset values; read 0x30 returns 0x00000000.
- With DMEM_MISALIGN_TRAP_EN: write be=1111 to addr 0x22 -> rsp_err=1 with rsp_valid, memory unchanged; without the macro -> write lands at word index 8, rsp_err=0.
